// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit hex seven-segment driver with per-slot dead time,
// frame-coherent shadow registers and optional leading-zero blanking.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    input  logic        en,
    output logic [3:0]  segEn,
    output logic [6:0]  sevSeg,
    output logic        segDec
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shVal;
    logic [3:0]    shDp;
    logic [3:0]    shBlank;
    logic          tick;
    logic          dead;
    logic [3:0]    digBlank;

    assign tick = (cnt == LAST);

    // Shadows reload only at the frame boundary so a frame never mixes old and new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= 2'd0;
            shVal   <= value;
            shDp    <= dp_in;
            shBlank <= blank;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    shVal   <= value;
                    shDp    <= dp_in;
                    shBlank <= blank;
                end
            end
        end
    end

    generate
        if (BLANK_CYC == 0) begin : gNoDead
            assign dead = 1'b0;
        end else begin : gDead
            assign dead = (cnt < CW'(BLANK_CYC));
        end

        for (genvar i = 0; i < 4; i++) begin : gDig
            if (i == 0 || LZ_SUPPRESS == 0) begin : gKeep
                assign digBlank[i] = shBlank[i];
            end else begin : gLz
                // Zero-suppressed when this nibble and every higher one are zero.
                assign digBlank[i] = shBlank[i] | ~|shVal[15:4*i];
            end
        end
    endgenerate

    logic [3:0] nibble;
    logic [6:0] hexSeg;
    logic [3:0] segEnNext;
    logic [6:0] sevSegNext;
    logic       segDecNext;

    always_comb begin
        nibble = shVal[idx*4 +: 4];
        hexSeg = 7'h7F;
        case (nibble)
            4'h0: hexSeg = 7'h40;
            4'h1: hexSeg = 7'h79;
            4'h2: hexSeg = 7'h24;
            4'h3: hexSeg = 7'h30;
            4'h4: hexSeg = 7'h19;
            4'h5: hexSeg = 7'h12;
            4'h6: hexSeg = 7'h02;
            4'h7: hexSeg = 7'h78;
            4'h8: hexSeg = 7'h00;
            4'h9: hexSeg = 7'h10;
            4'hA: hexSeg = 7'h08;
            4'hB: hexSeg = 7'h03;
            4'hC: hexSeg = 7'h46;
            4'hD: hexSeg = 7'h21;
            4'hE: hexSeg = 7'h06;
            4'hF: hexSeg = 7'h0E;
            default: hexSeg = 7'h7F;
        endcase
    end

    always_comb begin
        segEnNext  = 4'hF;
        sevSegNext = hexSeg;
        segDecNext = ~shDp[idx];
        if (en && !dead) segEnNext = ~(4'b0001 << idx);
        if (digBlank[idx]) begin
            sevSegNext = 7'h7F;
            segDecNext = 1'b1;
        end
    end

    // Anode and segment data share one register stage so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            segEn  <= 4'hF;
            sevSeg <= 7'h7F;
            segDec <= 1'b1;
        end else begin
            segEn  <= segEnNext;
            sevSeg <= sevSegNext;
            segDec <= segDecNext;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised and directed checks of seven_seg_scan against a cycle-count based
// reference model; two instances cover leading-zero suppression off and on.
module tb_seven_seg_scan;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        en;
    logic [3:0]  segEn0, segEn1;
    logic [6:0]  sevSeg0, sevSeg1;
    logic        segDec0, segDec1;

    seven_seg_scan #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK), .LZ_SUPPRESS(0)) d0 (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank(blank), .en(en),
        .segEn(segEn0), .sevSeg(sevSeg0), .segDec(segDec0));
    seven_seg_scan #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK), .LZ_SUPPRESS(1)) d1 (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank(blank), .en(en),
        .segEn(segEn1), .sevSeg(sevSeg1), .segDec(segDec1));

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Model: cycles elapsed since reset plus the frame snapshot of the inputs.
    int          t = 0;
    logic [15:0] mVal;
    logic [3:0]  mDp, mBlank;
    int          obsDig, obsPos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void expOut(input bit lz, output logic [3:0] an,
                                   output logic [6:0] sg, output logic dc);
        int  pos = t % DIV;
        int  dig = (t / DIV) % 4;
        int  nib = (mVal >> (4 * dig)) & 15;
        bit  blk = mBlank[dig] || (lz && dig >= 1 && (mVal >> (4 * dig)) == 0);
        an = (!en || pos < BLK) ? 4'hF : (4'hF ^ (4'h1 << dig));
        sg = blk ? 7'h7F : HEX[nib];
        dc = blk ? 1'b1 : !mDp[dig];
        if (rst) begin
            an = 4'hF;
            sg = 7'h7F;
            dc = 1'b1;
        end
    endfunction

    task automatic runCycle();
        logic [3:0] a0, a1;
        logic [6:0] s0, s1;
        logic       c0, c1;
        expOut(1'b0, a0, s0, c0);
        expOut(1'b1, a1, s1, c1);
        obsDig = rst ? -1 : (t / DIV) % 4;
        obsPos = rst ? -1 : t % DIV;
        @(posedge clk);
        if (rst) begin
            t = 0;
            mVal = value; mDp = dp_in; mBlank = blank;
        end else begin
            if (t % DIV == DIV - 1 && (t / DIV) % 4 == 3) begin
                mVal = value; mDp = dp_in; mBlank = blank;
            end
            t++;
        end
        #1;
        chk("segEn0", 32'(segEn0), 32'(a0));
        chk("sevSeg0", 32'(sevSeg0), 32'(s0));
        chk("segDec0", 32'(segDec0), 32'(c0));
        chk("segEn1", 32'(segEn1), 32'(a1));
        chk("sevSeg1", 32'(sevSeg1), 32'(s1));
        chk("segDec1", 32'(segDec1), 32'(c1));
    endtask

    task automatic runUntil(input int dig, input int pos);
        for (int i = 0; i < 80; i++) begin
            runCycle();
            if (obsDig == dig && obsPos == pos) return;
        end
        chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; value = 16'h1234; dp_in = 4'h0; blank = 4'h0;
        repeat (3) runCycle();
        chk("rstSegEn", 32'(segEn0), 32'hF);
        chk("rstSevSeg", 32'(sevSeg0), 32'h7F);
        chk("rstSegDec", 32'(segDec0), 32'h1);

        // Slot timing after release: two dead cycles then six lit cycles per digit.
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [6:0] want [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
            runCycle();
            chk("slotSeq", 32'(segEn0), (i % 8 < 2) ? 32'hF : 32'(4'hF ^ (4'h1 << (i / 8))));
            if (i % 8 == 4) chk("slotSeg", 32'(sevSeg0), 32'(want[i / 8]));
        end

        // Mid-frame value change must not appear until the next frame.
        runUntil(1, 4);
        value = 16'hABCD;
        runUntil(2, 4); chk("coh2old", 32'(sevSeg0), 32'h24);
        runUntil(3, 4); chk("coh3old", 32'(sevSeg0), 32'h79);
        runUntil(0, 4); chk("coh0new", 32'(sevSeg0), 32'h21);
        runUntil(1, 4); chk("coh1new", 32'(sevSeg0), 32'h46);
        runUntil(2, 4); chk("coh2new", 32'(sevSeg0), 32'h03);
        runUntil(3, 4); chk("coh3new", 32'(sevSeg0), 32'h08);

        // Leading-zero suppression.
        value = 16'h0050;
        runUntil(3, 7);
        runUntil(0, 4); chk("lz0", 32'(sevSeg1), 32'h40);
        runUntil(1, 4); chk("lz1", 32'(sevSeg1), 32'h12);
        runUntil(2, 4); chk("lz2", 32'(sevSeg1), 32'h7F); chk("lz2dp", 32'(segDec1), 32'h1);
        runUntil(3, 4); chk("lz3", 32'(sevSeg1), 32'h7F); chk("lz3dp", 32'(segDec1), 32'h1);
        chk("noLz3", 32'(sevSeg0), 32'h40);
        value = 16'h0000;
        runUntil(3, 7);
        runUntil(0, 4); chk("zero0", 32'(sevSeg1), 32'h40);
        runUntil(1, 4); chk("zero1", 32'(sevSeg1), 32'h7F);
        runUntil(2, 4); chk("zero2", 32'(sevSeg1), 32'h7F);
        runUntil(3, 4); chk("zero3", 32'(sevSeg1), 32'h7F);

        // Decimal point and forced blank.
        value = 16'h1234; dp_in = 4'b0100; blank = 4'b0001;
        runUntil(3, 7);
        runUntil(0, 4); chk("blk0seg", 32'(sevSeg0), 32'h7F); chk("blk0dp", 32'(segDec0), 32'h1);
        runUntil(2, 4); chk("dp2", 32'(segDec0), 32'h0); chk("dp2seg", 32'(sevSeg0), 32'h24);
        dp_in = 4'h0; blank = 4'h0;

        // Display disabled for one frame, then resumes in phase.
        runUntil(3, 7);
        en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            runCycle();
            chk("enOff", 32'(segEn0), 32'hF);
        end
        en = 1'b1;
        runCycle(); chk("resume0", 32'(segEn0), 32'hF);
        runUntil(0, 4); chk("resume4", 32'(segEn0), 32'hE);

        // Reset in the middle of a slot.
        runUntil(2, 4);
        rst = 1'b1;
        runCycle();
        chk("midRstEn", 32'(segEn0), 32'hF);
        chk("midRstSeg", 32'(sevSeg0), 32'h7F);
        chk("midRstDp", 32'(segDec0), 32'h1);
        rst = 1'b0;
        repeat (3) runCycle();
        chk("restart0", 32'(segEn0), 32'hE);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) value = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 31) == 0) value = {12'h0, 4'($urandom)};
            en  = ($urandom_range(0, 19) != 0);
            rst = ($urandom_range(0, 99) == 0);
            runCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
